// File: rtl/jtag_vector_sequencer.sv
// Sequences {TDI,TMS} vectors from an AXI-Stream slave through a JTAG shift engine
// and returns the length-masked TDO on an AXI-Stream master, with a DONE watchdog.
module jtag_vector_sequencer #(
  parameter int C_VEC_WIDTH      = 32,
  parameter int C_LEN_WIDTH      = 5,
  parameter int C_TIMEOUT_CYCLES = 65536,
  parameter int C_TIMEOUT_WIDTH  = 17,
  parameter int C_CAPTURE_TDO    = 1
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  input  logic [2*C_VEC_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [C_LEN_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                     S_AXIS_TLAST,
  output logic                     ENG_RESET,
  output logic                     ENG_ENABLE,
  input  logic                     ENG_DONE,
  output logic [C_VEC_WIDTH-1:0]   TMS_VECTOR,
  output logic [C_VEC_WIDTH-1:0]   TDI_VECTOR,
  output logic [C_LEN_WIDTH-1:0]   BIT_COUNT,
  input  logic [C_VEC_WIDTH-1:0]   TDO_VECTOR,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic [C_VEC_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                     M_AXIS_TUSER,
  output logic                     M_AXIS_TLAST,
  output logic                     ERROR,
  input  logic                     ERROR_CLR,
  output logic [31:0]              VEC_COUNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [C_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = C_TIMEOUT_WIDTH'(C_TIMEOUT_CYCLES - 1);
  localparam bit WATCHDOG_ON = (C_TIMEOUT_CYCLES > 0);
  localparam bit CAPTURE_ON  = (C_CAPTURE_TDO != 0);

  state_t                     state_r;
  logic [C_TIMEOUT_WIDTH-1:0] tcount_r;
  logic                       last_r;

  // Keeps bits 0..n of a captured TDO vector; n = width-1 passes everything.
  function automatic logic [C_VEC_WIDTH-1:0] len_mask(input logic [C_LEN_WIDTH-1:0] n);
    len_mask = {C_VEC_WIDTH{1'b1}} >> (C_VEC_WIDTH - 1 - int'(n));
  endfunction

  // Only accept a new vector when the single TDO beat slot is free or draining.
  assign S_AXIS_TREADY = (state_r == IDLE) && (!M_AXIS_TVALID || M_AXIS_TREADY);

  // Sequencer FSM with all engine, result and status outputs registered.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r       <= IDLE;
      tcount_r      <= '0;
      last_r        <= 1'b0;
      ENG_RESET     <= 1'b0;
      ENG_ENABLE    <= 1'b0;
      TMS_VECTOR    <= '0;
      TDI_VECTOR    <= '0;
      BIT_COUNT     <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      ERROR         <= 1'b0;
      VEC_COUNT     <= 32'd0;
    end else begin
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
      // A timeout later in this block overrides the clear.
      if (ERROR_CLR) begin
        ERROR <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          ENG_ENABLE <= 1'b0;
          if (S_AXIS_TVALID && S_AXIS_TREADY) begin
            TMS_VECTOR <= S_AXIS_TDATA[C_VEC_WIDTH-1:0];
            TDI_VECTOR <= S_AXIS_TDATA[2*C_VEC_WIDTH-1:C_VEC_WIDTH];
            BIT_COUNT  <= S_AXIS_TUSER;
            last_r     <= S_AXIS_TLAST;
            ENG_RESET  <= 1'b1;
            state_r    <= ARM;
          end
        end
        ARM: begin
          ENG_RESET  <= 1'b0;
          ENG_ENABLE <= 1'b1;
          tcount_r   <= '0;
          state_r    <= RUN;
        end
        RUN: begin
          if (ENG_DONE) begin
            M_AXIS_TVALID <= CAPTURE_ON;
            M_AXIS_TDATA  <= TDO_VECTOR & len_mask(BIT_COUNT);
            M_AXIS_TUSER  <= 1'b0;
            M_AXIS_TLAST  <= last_r;
            VEC_COUNT     <= VEC_COUNT + 32'd1;
            ENG_ENABLE    <= 1'b0;
            state_r       <= IDLE;
          end else if (WATCHDOG_ON && (tcount_r == TIMEOUT_LAST)) begin
            ERROR         <= 1'b1;
            M_AXIS_TVALID <= CAPTURE_ON;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TUSER  <= 1'b1;
            M_AXIS_TLAST  <= last_r;
            ENG_ENABLE    <= 1'b0;
            state_r       <= IDLE;
          end else begin
            tcount_r <= tcount_r + C_TIMEOUT_WIDTH'(1);
          end
        end
        default: begin
          ENG_RESET  <= 1'b0;
          ENG_ENABLE <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_vector_sequencer.sv
// Directed bench for jtag_vector_sequencer: a scoreboard queue holds expected TDO
// beats pushed at stimulus time and popped by a monitor at each M_AXIS handshake.
module tb_jtag_vector_sequencer;

  logic        CLK;
  logic        RESETN;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [63:0] S_AXIS_TDATA;
  logic [4:0]  S_AXIS_TUSER;
  logic        S_AXIS_TLAST;
  logic        ENG_RESET;
  logic        ENG_ENABLE;
  logic        ENG_DONE;
  logic [31:0] TMS_VECTOR;
  logic [31:0] TDI_VECTOR;
  logic [4:0]  BIT_COUNT;
  logic [31:0] TDO_VECTOR;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TUSER;
  logic        M_AXIS_TLAST;
  logic        ERROR;
  logic        ERROR_CLR;
  logic [31:0] VEC_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  logic [33:0] exp_q[$];

  jtag_vector_sequencer #(
    .C_VEC_WIDTH(32), .C_LEN_WIDTH(5), .C_TIMEOUT_CYCLES(16),
    .C_TIMEOUT_WIDTH(5), .C_CAPTURE_TDO(1)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TLAST(S_AXIS_TLAST),
    .ENG_RESET(ENG_RESET), .ENG_ENABLE(ENG_ENABLE), .ENG_DONE(ENG_DONE),
    .TMS_VECTOR(TMS_VECTOR), .TDI_VECTOR(TDI_VECTOR), .BIT_COUNT(BIT_COUNT),
    .TDO_VECTOR(TDO_VECTOR),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
    .ERROR(ERROR), .ERROR_CLR(ERROR_CLR), .VEC_COUNT(VEC_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Independent reference: keep TDO bits 0..n.
  function automatic logic [31:0] ref_mask(input logic [31:0] tdo, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i <= n) r[i] = tdo[i];
    end
    return r;
  endfunction

  task automatic push_beat(input logic [31:0] data, input logic user, input logic last);
    exp_q.push_back({last, user, data});
  endtask

  // Offer a vector, wait (bounded) for acceptance, then check the ARM cycle.
  task automatic offer(input logic [31:0] tms, input logic [31:0] tdi, input logic [4:0] n,
                       input logic last);
    bit ok;
    ok = 1'b0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = {tdi, tms};
    S_AXIS_TUSER  = n;
    S_AXIS_TLAST  = last;
    for (int k = 0; k < 200; k++) begin
      if (S_AXIS_TREADY) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("s_accept_timeout", 64'(ok), 64'd1);
    step();
    S_AXIS_TVALID = 1'b0;
    chk("arm_eng_reset", 64'(ENG_RESET), 64'd1);
    chk("arm_eng_enable", 64'(ENG_ENABLE), 64'd0);
    chk("tms_latch", 64'(TMS_VECTOR), 64'(tms));
    chk("tdi_latch", 64'(TDI_VECTOR), 64'(tdi));
    chk("bit_count_latch", 64'(BIT_COUNT), 64'(n));
  endtask

  // Run the engine for 'delay' enabled cycles, then pulse DONE with the given TDO.
  task automatic engine(input int delay, input logic [31:0] tdo);
    step();
    chk("run_eng_reset", 64'(ENG_RESET), 64'd0);
    chk("run_eng_enable", 64'(ENG_ENABLE), 64'd1);
    for (int k = 1; k < delay; k++) step();
    ENG_DONE   = 1'b1;
    TDO_VECTOR = tdo;
    step();
    ENG_DONE = 1'b0;
    chk("done_enable_drop", 64'(ENG_ENABLE), 64'd0);
    chk("done_tvalid", 64'(M_AXIS_TVALID), 64'd1);
  endtask

  // Scoreboard monitor: compare each handshaken beat with the queue head.
  always @(negedge CLK) begin
    if (RESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("beat_tdata", 64'(M_AXIS_TDATA), 64'(e[31:0]));
        chk("beat_tuser", 64'(M_AXIS_TUSER), 64'(e[32]));
        chk("beat_tlast", 64'(M_AXIS_TLAST), 64'(e[33]));
      end
    end
  end

  initial begin
    int enable_cycles;
    logic [31:0] tdos [4];
    int lens [4];
    RESETN = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = 64'd0; S_AXIS_TUSER = 5'd0;
    S_AXIS_TLAST = 1'b0; ENG_DONE = 1'b0; TDO_VECTOR = 32'd0; M_AXIS_TREADY = 1'b1;
    ERROR_CLR = 1'b0;
    step(); step();
    chk("rst_eng_reset", 64'(ENG_RESET), 64'd0);
    chk("rst_eng_enable", 64'(ENG_ENABLE), 64'd0);
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    chk("rst_vec_count", 64'(VEC_COUNT), 64'd0);
    chk("rst_tms", 64'(TMS_VECTOR), 64'd0);
    RESETN = 1'b1;
    step();
    chk("idle_s_tready", 64'(S_AXIS_TREADY), 64'd1);

    // Full-length vector, DONE 10 cycles after enable.
    push_beat(32'h12345678, 1'b0, 1'b1);
    offer(32'h0000001F, 32'hA5A5A5A5, 5'd31, 1'b1);
    engine(10, 32'h12345678);
    chk("vec_count_1", 64'(VEC_COUNT), 64'd1);
    step();

    // Short vector: only 8 bits survive the mask.
    push_beat(ref_mask(32'hFFFFFFFF, 7), 1'b0, 1'b0);
    offer(32'h00000003, 32'h0000005A, 5'd7, 1'b0);
    engine(3, 32'hFFFFFFFF);
    chk("vec_count_2", 64'(VEC_COUNT), 64'd2);
    step();

    // Back-pressure: beat held 20 cycles while a second vector waits.
    M_AXIS_TREADY = 1'b0;
    push_beat(ref_mask(32'hDEADBEEF, 15), 1'b0, 1'b0);
    offer(32'h0000FFFF, 32'h00001234, 5'd15, 1'b0);
    engine(2, 32'hDEADBEEF);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = {32'h0000000C, 32'h00000005};
    S_AXIS_TUSER  = 5'd3;
    S_AXIS_TLAST  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("stall_s_tready", 64'(S_AXIS_TREADY), 64'd0);
      chk("stall_tdata", 64'(M_AXIS_TDATA), 64'h0000BEEF);
      chk("stall_tvalid", 64'(M_AXIS_TVALID), 64'd1);
    end
    M_AXIS_TREADY = 1'b1;
    #1;
    chk("release_s_tready", 64'(S_AXIS_TREADY), 64'd1);
    push_beat(ref_mask(32'hFFFFFFFA, 3), 1'b0, 1'b1);
    offer(32'h00000005, 32'h0000000C, 5'd3, 1'b1);
    chk("release_tvalid_drop", 64'(M_AXIS_TVALID), 64'd0);
    engine(4, 32'hFFFFFFFA);
    chk("vec_count_4", 64'(VEC_COUNT), 64'd4);
    step();

    // Watchdog: DONE never comes.
    push_beat(32'd0, 1'b1, 1'b0);
    offer(32'h11111111, 32'h22222222, 5'd31, 1'b0);
    enable_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (ENG_ENABLE) enable_cycles++;
      else break;
    end
    chk("timeout_enable_cycles", 64'(enable_cycles), 64'd16);
    chk("timeout_error", 64'(ERROR), 64'd1);
    chk("timeout_tvalid", 64'(M_AXIS_TVALID), 64'd1);
    chk("timeout_vec_count", 64'(VEC_COUNT), 64'd4);
    step();
    ERROR_CLR = 1'b1;
    step();
    ERROR_CLR = 1'b0;
    chk("error_clr", 64'(ERROR), 64'd0);

    // Asynchronous reset in the middle of RUN.
    offer(32'h33333333, 32'h44444444, 5'd31, 1'b1);
    step(); step();
    chk("pre_reset_enable", 64'(ENG_ENABLE), 64'd1);
    #2 RESETN = 1'b0;
    #1;
    chk("areset_enable", 64'(ENG_ENABLE), 64'd0);
    chk("areset_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("areset_vec_count", 64'(VEC_COUNT), 64'd0);
    step();
    RESETN = 1'b1;
    ENG_DONE = 1'b1;
    TDO_VECTOR = 32'hCAFEF00D;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_reset_no_beat", 64'(M_AXIS_TVALID), 64'd0);
    end
    ENG_DONE = 1'b0;
    chk("post_reset_vec_count", 64'(VEC_COUNT), 64'd0);

    // Four-vector packet with TLAST on the last beat.
    tdos[0] = 32'h89ABCDEF; lens[0] = 31;
    tdos[1] = 32'h00000003; lens[1] = 0;
    tdos[2] = 32'hF0F0F0F0; lens[2] = 20;
    tdos[3] = 32'h13579BDF; lens[3] = 31;
    for (int v = 0; v < 4; v++) begin
      push_beat(ref_mask(tdos[v], lens[v]), 1'b0, (v == 3) ? 1'b1 : 1'b0);
      offer(32'h0 + 32'(v), 32'hFFFF0000 + 32'(v), 5'(lens[v]), (v == 3) ? 1'b1 : 1'b0);
      engine(2 + v, tdos[v]);
    end
    chk("packet_vec_count", 64'(VEC_COUNT), 64'd4);

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("beats_seen", 64'(beats_seen), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
